// File: rtl/fft_delay_line_if.sv
// fft_delay_line_if: control, sample and status bundle for the runtime-configurable delay line
interface fft_delay_line_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 16,
  parameter int DW       = 4
);
  logic                      en;
  logic                      flush;
  logic                      load_cfg;
  logic [DW-1:0]             delay_sel;
  logic                      in_valid;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic                      out_valid;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [DW-1:0]             cfg_delay;
  logic                      primed;
  modport master (
    output en, flush, load_cfg, delay_sel, in_valid, in_data,
    input  out_valid, out_data, cfg_delay, primed
  );
  modport slave (
    input  en, flush, load_cfg, delay_sel, in_valid, in_data,
    output out_valid, out_data, cfg_delay, primed
  );
endinterface

// File: rtl/fft_delay_line.sv
// fft_delay_line: multi-lane delay line with runtime delay select, valid tracking, stall and flush
module fft_delay_line #(
  parameter int CHANNELS  = 2,
  parameter int WIDTH     = 16,
  parameter int MAX_DEPTH = 8,
  parameter int DW        = $clog2(MAX_DEPTH + 1)
) (
  input logic             clk,
  input logic             rst_n,
  fft_delay_line_if.slave b
);
  logic [CHANNELS*WIDTH-1:0] data_q [MAX_DEPTH];
  logic [CHANNELS*WIDTH-1:0] data_d [MAX_DEPTH];
  logic [MAX_DEPTH-1:0]      vld_q, vld_d;
  logic [DW-1:0]             cfg_q, cfg_d, cnt_q, cnt_d, sel_sat;
  assign sel_sat     = b.delay_sel > DW'(MAX_DEPTH) ? DW'(MAX_DEPTH) : b.delay_sel;
  assign b.cfg_delay = cfg_q;
  assign b.primed    = cnt_q == cfg_q;
  // Load and flush both invalidate the chain; data bits are kept to avoid a wide clear
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    cnt_d  = cnt_q;
    cfg_d  = b.load_cfg ? sel_sat : cfg_q;
    if (b.load_cfg || b.flush) begin
      vld_d = '0;
      cnt_d = '0;
    end else if (b.en) begin
      data_d[0] = b.in_data;
      vld_d[0]  = b.in_valid;
      for (int k = 1; k < MAX_DEPTH; k++) begin
        data_d[k] = data_q[k-1];
        vld_d[k]  = vld_q[k-1];
      end
      cnt_d = cnt_q < cfg_q ? cnt_q + DW'(1) : cnt_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MAX_DEPTH; k++) data_q[k] <= '0;
      vld_q <= '0;
      cfg_q <= DW'(1);
      cnt_q <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      cfg_q  <= cfg_d;
      cnt_q  <= cnt_d;
    end
  end
  // Delay 0 bypasses the chain combinationally; otherwise tap stage D-1
  always_comb begin
    b.out_data  = b.in_data;
    b.out_valid = b.in_valid;
    for (int k = 0; k < MAX_DEPTH; k++) begin
      if (cfg_q == DW'(k + 1)) begin
        b.out_data  = data_q[k];
        b.out_valid = vld_q[k];
      end
    end
  end
endmodule

// File: tb/tb_fft_delay_line.sv
// tb_fft_delay_line: scoreboard bench for fft_delay_line covering latency, stall, reload, flush, saturation and bypass
module tb_fft_delay_line;
  localparam int CH = 2, W = 16, MD = 8, DW = 4;
  typedef struct {
    logic [CH*W-1:0] data;
    int              due;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  fft_delay_line_if #(.CHANNELS(CH), .WIDTH(W), .DW(DW)) b ();
  fft_delay_line #(.CHANNELS(CH), .WIDTH(W), .MAX_DEPTH(MD)) dut (.clk(clk), .rst_n(rst_n), .b(b));
  always #5 clk = ~clk;
  exp_t q[$];
  int   n_checks = 0, n_fail = 0;
  int   d = 1, pcnt = 0, nshift = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic check_outputs();
    logic ev;
    if (d == 0) begin
      chk("byp_valid", b.out_valid, b.in_valid);
      chk("byp_data", b.out_data, b.in_data);
    end else begin
      ev = q.size() > 0 && q[0].due == nshift;
      chk("out_valid", b.out_valid, ev);
      if (ev) chk("out_data", b.out_data, q[0].data);
    end
    chk("cfg_delay", b.cfg_delay, d);
    chk("primed", b.primed, pcnt == d);
  endtask
  task automatic tick(input logic e, input logic v, input logic [15:0] k,
                      input logic f, input logic l, input logic [3:0] s);
    b.en = e; b.in_valid = v; b.in_data = {16'hA000 ^ k, k};
    b.flush = f; b.load_cfg = l; b.delay_sel = s;
    @(posedge clk);
    if (l || f) begin
      q.delete();
      pcnt = 0;
      if (l) d = s > MD ? MD : s;
    end else if (e) begin
      if (q.size() > 0 && q[0].due == nshift) void'(q.pop_front());
      nshift++;
      if (v && d > 0) q.push_back('{{16'hA000 ^ k, k}, nshift + d - 1});
      if (pcnt < d) pcnt++;
    end
    #1;
    check_outputs();
  endtask
  task automatic stream(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) tick(1'b1, 1'b1, 16'(k), 1'b0, 1'b0, 4'd0);
  endtask
  task automatic drain(input int n, input string tag);
    repeat (n) tick(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 4'd0);
    chk(tag, q.size(), 0);
  endtask
  task automatic load(input logic [3:0] s);
    tick(1'b1, 1'b0, 16'd0, 1'b0, 1'b1, s);
  endtask
  initial begin
    b.en = 0; b.flush = 0; b.load_cfg = 0; b.delay_sel = '0; b.in_valid = 0; b.in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", b.out_valid, 0);
    chk("rst_data", b.out_data, 0);
    chk("rst_cfg", b.cfg_delay, 1);
    chk("rst_primed", b.primed, 0);
    rst_n = 1'b1;
    tick(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 4'd0);
    load(4'd3);
    stream(1, 10);
    drain(4, "drain_d3");
    for (int k = 1; k <= 10; k++) begin
      tick(1'b1, 1'b1, 16'(k), 1'b0, 1'b0, 4'd0);
      if (k == 4) repeat (2) tick(1'b0, 1'b1, 16'd5, 1'b0, 1'b0, 4'd0);
    end
    drain(4, "drain_stall");
    stream(1, 6);
    tick(1'b1, 1'b1, 16'd7, 1'b0, 1'b1, 4'd5);
    stream(7, 12);
    drain(7, "drain_reload");
    stream(1, 3);
    tick(1'b1, 1'b1, 16'd4, 1'b1, 1'b0, 4'd0);
    drain(7, "drain_flush");
    stream(4, 6);
    drain(7, "drain_postflush");
    load(4'd9);
    stream(1, 4);
    drain(10, "drain_sat");
    load(4'd0);
    for (int k = 20; k < 24; k++) tick(1'b1, k[0], 16'(k), 1'b0, 1'b0, 4'd0);
    b.in_data = 32'h1234_5678;
    #1;
    chk("byp_comb", b.out_data, 32'h1234_5678);
    load(4'd2);
    stream(1, 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", b.out_valid, 0);
    chk("mid_rst_data", b.out_data, 0);
    chk("mid_rst_cfg", b.cfg_delay, 1);
    chk("mid_rst_primed", b.primed, 0);
    q.delete(); d = 1; pcnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stream(1, 3);
    drain(3, "drain_after_rst");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
